neosd_dat_rx: RTL and testbench
===============================

# neosd_dat_rx

Receive-side framer for the SD DAT0 line in 1-bit bus mode. Once armed, it waits for a start bit and assembles the following serial data bits, MSB first, into 32-bit words. It then checks the trailing CRC16 and end bit, and hands words to the controller through a valid/ready handshake. It sits between the SD pad sampler and the controller's read FIFO, and is clocked by the fast system clock qualified by the SD clock strobe.

## Interface
Parameters:
- TIMEOUT_STRB, 1024: number of SD clock strobes to wait for a start bit before giving up (must be ≥ 1).

Ports:
- clk_i  in  1  fast system clock
- rstn_i  in  1  reset, asynchronous, active-low
- clkstrb_i  in  1  one-cycle strobe marking the SD clock sampling edge
- start_i  in  1  arm receiver for one block; ignored unless idle
- abort_i  in  1  return to idle immediately; highest priority after reset
- blklen_i  in  8  block length in 32-bit words; 0 means 256; captured on start_i
- dat_i  in  1  DAT0 serial input, already synchronised
- word_o  out  32  received word
- word_valid_o  out  1  word_o holds an unconsumed word
- word_ready_i  in  1  consumer accepts word_o when valid and ready are both high
- busy_o  out  1  high in every state except IDLE
- done_o  out  1  one-cycle pulse at block completion, including timeout
- crc_err_o  out  1  received CRC16 ≠ computed CRC16
- end_err_o  out  1  end bit sampled as 0
- timeout_o  out  1  no start bit within TIMEOUT_STRB strobes
- overrun_o  out  1  a word completed while word_valid_o was still high

## Operation
- Reset: state IDLE. All outputs are 0, including word_o, and all counters and the CRC register are 0.
- Sampling: dat_i is used only in clk_i cycles with clkstrb_i = 1. Exactly one bit is consumed per strobe.
- IDLE: start_i = 1 has the following effects.
  - Captures blklen_i.
  - Clears crc_err_o, end_err_o, timeout_o and overrun_o.
  - Clears the CRC register and the timeout counter.
  - Enters WAIT_START.
- WAIT_START: on each strobe:
  - dat_i = 0 is the start bit, and the state goes to DATA.
  - Otherwise the timeout counter increments. When the counter reaches TIMEOUT_STRB, set timeout_o and go to DONE.
- DATA: each strobe does three things.
  - Shifts dat_i into the LSB of the shift register.
  - Updates the CRC16-CCITT (poly 0x1021, init 0x0000, MSB first) with dat_i.
  - Increments the bit counter (5 bits, wraps at 32).
- Word completion, on the 32nd bit of a word:
  - word_o is loaded with the full word and word_valid_o is set.
  - If word_valid_o was already 1 and no handshake occurs in the same cycle, set overrun_o. The new word overwrites the old one.
  - Increment the word counter. After word number blklen (256 when blklen_i = 0), go to CRC.
- CRC: 16 strobes shift the received CRC in, MSB first. After the 16th, compare it with the computed CRC and set crc_err_o on mismatch. Go to END.
- END: on one strobe, set end_err_o if dat_i = 0. Go to DONE.
- DONE: lasts one cycle with done_o = 1, then returns to IDLE.
- Error flags hold their value until the next accepted start_i.
- Handshake: word_valid_o clears in a cycle where word_ready_i = 1. If a word completes in that same cycle, word_valid_o stays 1 with the new word and no overrun is flagged.
- abort_i in any state:
  - Go to IDLE next cycle.
  - Clear word_valid_o.
  - Do not pulse done_o.
  - Leave the error flags unchanged.
- start_i outside IDLE is ignored. start_i and abort_i together: abort wins.

## Timing
- All outputs are registered.
- word_valid_o rises in the clk_i cycle after the strobe cycle that sampled bit 0 of the word.
- done_o rises in the cycle after the END strobe, or after the final timeout strobe.
- crc_err_o is valid in the cycle after the 16th CRC strobe. end_err_o and timeout_o are valid when done_o is high.
- busy_o rises in the cycle after start_i and falls in the cycle after done_o.
- Back-to-back strobes on consecutive clk_i cycles are supported. The maximum bit rate is one bit per clk_i cycle.
- Latency from the last data bit to done_o is 17 strobes plus 1 cycle.

## Test plan
- Clean block: blklen_i = 128, 512 bytes of 0xFF, CRC 0x7FA1, end bit 1, word_ready_i tied high. Expect 128 words of 0xFFFFFFFF, then done_o with all error flags 0.
- Corrupted CRC: same block with CRC sent as 0x7FA0. Expect crc_err_o = 1 at done_o and all 128 words still delivered.
- Timeout: TIMEOUT_STRB = 8, dat_i held at 1. Expect done_o with timeout_o = 1 after the 8th strobe and no words delivered.
- Overrun and back-pressure: blklen_i = 2, words 0x12345678 and 0x9ABCDEF0, word_ready_i held low. Expect overrun_o = 1 and word_o = 0x9ABCDEF0. Repeat with ready asserted in the completion cycle: overrun_o = 0.
- Bad end bit: blklen_i = 1 with a correct CRC and end bit 0. Expect end_err_o = 1 and crc_err_o = 0.
- Abort and reset mid-block: abort_i during word 3 of 8. Expect IDLE next cycle, word_valid_o = 0 and no done_o pulse; a new start_i then receives correctly. rstn_i low mid-block zeroes all outputs asynchronously.

Source files
------------

// File: rtl/neosd_dat_rx.sv
// -----------------------------------------------------------------------------
// neosd_dat_rx
// Receive framer for SD DAT0 in 1-bit mode. Once armed, it waits for a start
// bit and assembles MSB-first 32-bit words. It then checks the trailing CRC16
// and end bit, and presents each word on a valid/ready handshake.
//
// Ports:
//   clk_i         fast system clock
//   rstn_i        asynchronous active-low reset
//   clkstrb_i     SD clock sampling strobe (one bit consumed per strobe)
//   start_i       arm for one block (only honoured in IDLE)
//   abort_i       return to IDLE immediately, no done pulse
//   blklen_i      block length in words, 0 = 256 (captured on start_i)
//   dat_i         synchronised DAT0 input
//   word_o        received word
//   word_valid_o  word_o holds an unconsumed word
//   word_ready_i  consumer accepts word_o
//   busy_o        not IDLE
//   done_o        one-cycle pulse at block end (also on timeout)
//   crc_err_o     received CRC16 differs from computed CRC16
//   end_err_o     end bit sampled as 0
//   timeout_o     no start bit within TIMEOUT_STRB strobes
//   overrun_o     a word completed while the previous one was unconsumed
// -----------------------------------------------------------------------------
module neosd_dat_rx #(
  parameter int unsigned TIMEOUT_STRB = 1024
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic        clkstrb_i,
  input  logic        start_i,
  input  logic        abort_i,
  input  logic [7:0]  blklen_i,
  input  logic        dat_i,
  output logic [31:0] word_o,
  output logic        word_valid_o,
  input  logic        word_ready_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        crc_err_o,
  output logic        end_err_o,
  output logic        timeout_o,
  output logic        overrun_o
);

  localparam int unsigned TW = $clog2(TIMEOUT_STRB + 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_WAIT  = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_CRC   = 3'd3;
  localparam logic [2:0] S_END   = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  logic [2:0]    state;
  logic [7:0]    blklen_r;
  logic [7:0]    word_cnt;
  logic [4:0]    bit_cnt;
  logic [TW-1:0] tmo_cnt;
  logic [15:0]   crc;
  logic [14:0]   crc_rx;   // top bit is never needed: the 16th bit comes straight from dat_i
  logic [30:0]   sreg;     // likewise for the word shift register

  logic [31:0]   word_next;
  logic [15:0]   crc_next;
  logic [15:0]   crc_rx_full;

  always_comb begin
    word_next   = {sreg, dat_i};
    crc_rx_full = {crc_rx, dat_i};
    crc_next    = {crc[14:0], 1'b0} ^ ((crc[15] ^ dat_i) ? 16'h1021 : 16'h0000);
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state        <= S_IDLE;
      blklen_r     <= '0;
      word_cnt     <= '0;
      bit_cnt      <= '0;
      tmo_cnt      <= '0;
      crc          <= '0;
      crc_rx       <= '0;
      sreg         <= '0;
      word_o       <= '0;
      word_valid_o <= 1'b0;
      busy_o       <= 1'b0;
      done_o       <= 1'b0;
      crc_err_o    <= 1'b0;
      end_err_o    <= 1'b0;
      timeout_o    <= 1'b0;
      overrun_o    <= 1'b0;
    end else begin
      done_o <= 1'b0;
      // Consumption first; a word completing in the same cycle overrides below.
      if (word_ready_i) word_valid_o <= 1'b0;

      if (abort_i) begin
        state        <= S_IDLE;
        busy_o       <= 1'b0;
        word_valid_o <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (start_i) begin
              blklen_r  <= blklen_i;
              crc_err_o <= 1'b0;
              end_err_o <= 1'b0;
              timeout_o <= 1'b0;
              overrun_o <= 1'b0;
              crc       <= '0;
              tmo_cnt   <= '0;
              bit_cnt   <= '0;
              word_cnt  <= '0;
              busy_o    <= 1'b1;
              state     <= S_WAIT;
            end
          end
          S_WAIT: begin
            if (clkstrb_i) begin
              if (!dat_i) begin
                state <= S_DATA;
              end else begin
                tmo_cnt <= tmo_cnt + 1'b1;
                if (tmo_cnt == TW'(TIMEOUT_STRB - 1)) begin
                  timeout_o <= 1'b1;
                  done_o    <= 1'b1;
                  state     <= S_DONE;
                end
              end
            end
          end
          S_DATA: begin
            if (clkstrb_i) begin
              sreg    <= word_next[30:0];
              crc     <= crc_next;
              bit_cnt <= bit_cnt + 1'b1;
              if (bit_cnt == 5'd31) begin
                word_o       <= word_next;
                word_valid_o <= 1'b1;
                if (word_valid_o && !word_ready_i) overrun_o <= 1'b1;
                word_cnt <= word_cnt + 1'b1;
                // blklen 0 wraps to 255 here, giving 256 words
                if (word_cnt == blklen_r - 8'd1) state <= S_CRC;
              end
            end
          end
          S_CRC: begin
            if (clkstrb_i) begin
              crc_rx  <= crc_rx_full[14:0];
              bit_cnt <= bit_cnt + 1'b1;
              if (bit_cnt == 5'd15) begin
                crc_err_o <= (crc_rx_full != crc);
                bit_cnt   <= '0;
                state     <= S_END;
              end
            end
          end
          S_END: begin
            if (clkstrb_i) begin
              end_err_o <= ~dat_i;
              done_o    <= 1'b1;
              state     <= S_DONE;
            end
          end
          S_DONE: begin
            busy_o <= 1'b0;
            state  <= S_IDLE;
          end
          default: begin
            busy_o <= 1'b0;
            state  <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_neosd_dat_rx.sv
// -----------------------------------------------------------------------------
// tb_neosd_dat_rx
// Directed bench for neosd_dat_rx: clean block, corrupted CRC, timeout,
// overrun/back-pressure, bad end bit, abort and asynchronous reset mid-block.
// -----------------------------------------------------------------------------
module tb_neosd_dat_rx;

  logic        clk_i;
  logic        rstn_i;
  logic        clkstrb_i;
  logic        start_i;
  logic        abort_i;
  logic [7:0]  blklen_i;
  logic        dat_i;
  logic [31:0] word_o;
  logic        word_valid_o;
  logic        word_ready_i;
  logic        busy_o;
  logic        done_o;
  logic        crc_err_o;
  logic        end_err_o;
  logic        timeout_o;
  logic        overrun_o;

  neosd_dat_rx #(.TIMEOUT_STRB(8)) dut (
    .clk_i        (clk_i),
    .rstn_i       (rstn_i),
    .clkstrb_i    (clkstrb_i),
    .start_i      (start_i),
    .abort_i      (abort_i),
    .blklen_i     (blklen_i),
    .dat_i        (dat_i),
    .word_o       (word_o),
    .word_valid_o (word_valid_o),
    .word_ready_i (word_ready_i),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .crc_err_o    (crc_err_o),
    .end_err_o    (end_err_o),
    .timeout_o    (timeout_o),
    .overrun_o    (overrun_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;

  // Monitor: sampled on the falling edge, inputs change at posedge+2.
  logic [31:0] words_q[$];
  int          done_cnt;
  logic        d_crc, d_end, d_tmo, d_ovr;

  always @(negedge clk_i) begin
    if (word_valid_o && word_ready_i) words_q.push_back(word_o);
    if (done_o) begin
      done_cnt = done_cnt + 1;
      d_crc = crc_err_o;
      d_end = end_err_o;
      d_tmo = timeout_o;
      d_ovr = overrun_o;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [31:0] wq[$];

  function automatic logic [15:0] calc_crc(input logic [31:0] w[$]);
    logic [15:0] c;
    logic        fb;
    c = 16'h0000;
    foreach (w[k]) begin
      for (int i = 31; i >= 0; i--) begin
        fb = c[15] ^ w[k][i];
        c  = {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
      end
    end
    return c;
  endfunction

  task automatic tick();
    @(posedge clk_i);
    #2;
  endtask

  task automatic strobe(input logic b, input int gap);
    dat_i     = b;
    clkstrb_i = 1'b1;
    tick();
    clkstrb_i = 1'b0;
    dat_i     = 1'b1;
    repeat (gap) tick();
  endtask

  task automatic send_word(input logic [31:0] w, input int gap);
    for (int i = 31; i >= 0; i--) strobe(w[i], gap);
  endtask

  task automatic do_start(input logic [7:0] len);
    words_q.delete();
    done_cnt  = 0;
    blklen_i  = len;
    start_i   = 1'b1;
    tick();
    start_i   = 1'b0;
  endtask

  task automatic wait_done();
    for (int n = 0; n < 20 && done_cnt == 0; n++) tick();
    checks++;
    if (done_cnt != 1) begin
      errors++;
      $display("FAIL done_pulse: got %0d done pulses, expected 1", done_cnt);
    end
  endtask

  task automatic send_block(input logic [31:0] w[$], input logic [15:0] crc,
                            input logic end_bit, input int gap);
    strobe(1'b1, gap);
    strobe(1'b1, gap);
    strobe(1'b0, gap);
    foreach (w[k]) send_word(w[k], gap);
    for (int i = 15; i >= 0; i--) strobe(crc[i], gap);
    strobe(end_bit, gap);
    wait_done();
  endtask

  task automatic test_reset();
    rstn_i = 1'b1;
    #1 rstn_i = 1'b0;
    repeat (3) tick();
    checks++;
    if ({word_o, word_valid_o, busy_o, done_o, crc_err_o, end_err_o, timeout_o, overrun_o} !== '0) begin
      errors++;
      $display("FAIL reset_hold: outputs %h word %h, expected all 0", 
               {word_valid_o, busy_o, done_o, crc_err_o, end_err_o, timeout_o, overrun_o}, word_o);
    end
    rstn_i = 1'b1;
    repeat (2) tick();
    checks++;
    if ({word_o, word_valid_o, busy_o, done_o, crc_err_o, end_err_o, timeout_o, overrun_o} !== '0) begin
      errors++;
      $display("FAIL reset_release: outputs %h word %h, expected all 0",
               {word_valid_o, busy_o, done_o, crc_err_o, end_err_o, timeout_o, overrun_o}, word_o);
    end
  endtask

  task automatic test_clean();
    int bad;
    word_ready_i = 1'b1;
    wq.delete();
    for (int i = 0; i < 128; i++) wq.push_back(32'hFFFF_FFFF);
    do_start(8'd128);
    checks++;
    if (busy_o !== 1'b1) begin
      errors++;
      $display("FAIL clean_busy_rise: busy_o=%b expected 1", busy_o);
    end
    send_block(wq, 16'h7FA1, 1'b1, 0);
    bad = 0;
    foreach (words_q[k]) if (words_q[k] !== 32'hFFFF_FFFF) bad++;
    checks++;
    if (words_q.size() != 128 || bad != 0) begin
      errors++;
      $display("FAIL clean_words: got %0d words (%0d wrong), expected 128 of ffffffff", words_q.size(), bad);
    end
    checks++;
    if ({d_crc, d_end, d_tmo, d_ovr} !== 4'b0000) begin
      errors++;
      $display("FAIL clean_flags: crc/end/tmo/ovr=%b expected 0000", {d_crc, d_end, d_tmo, d_ovr});
    end
    repeat (2) tick();
    checks++;
    if (busy_o !== 1'b0) begin
      errors++;
      $display("FAIL clean_busy_fall: busy_o=%b expected 0", busy_o);
    end
  endtask

  task automatic test_crc_err();
    word_ready_i = 1'b1;
    do_start(8'd128);
    send_block(wq, 16'h7FA0, 1'b1, 1);
    checks++;
    if (d_crc !== 1'b1 || d_end !== 1'b0) begin
      errors++;
      $display("FAIL crc_err_flag: crc_err=%b end_err=%b expected 1 0", d_crc, d_end);
    end
    checks++;
    if (words_q.size() != 128) begin
      errors++;
      $display("FAIL crc_err_words: got %0d words expected 128", words_q.size());
    end
  endtask

  task automatic test_timeout();
    do_start(8'd4);
    for (int i = 0; i < 7; i++) strobe(1'b1, 1);
    checks++;
    if (done_cnt != 0 || busy_o !== 1'b1) begin
      errors++;
      $display("FAIL timeout_early: done pulses %0d busy %b expected 0 1", done_cnt, busy_o);
    end
    strobe(1'b1, 1);
    checks++;
    if (done_cnt != 1 || d_tmo !== 1'b1) begin
      errors++;
      $display("FAIL timeout_flag: done pulses %0d timeout %b expected 1 1", done_cnt, d_tmo);
    end
    checks++;
    if (words_q.size() != 0) begin
      errors++;
      $display("FAIL timeout_words: got %0d words expected 0", words_q.size());
    end
    tick();
    checks++;
    if (busy_o !== 1'b0 || timeout_o !== 1'b1) begin
      errors++;
      $display("FAIL timeout_idle: busy %b timeout %b expected 0 1", busy_o, timeout_o);
    end
  endtask

  task automatic test_overrun();
    logic [31:0] w2;
    w2 = 32'h9ABC_DEF0;
    wq.delete();
    wq.push_back(32'h1234_5678);
    wq.push_back(w2);
    word_ready_i = 1'b0;
    do_start(8'd2);
    send_block(wq, calc_crc(wq), 1'b1, 1);
    checks++;
    if (d_ovr !== 1'b1 || d_crc !== 1'b0) begin
      errors++;
      $display("FAIL overrun_flag: overrun %b crc_err %b expected 1 0", d_ovr, d_crc);
    end
    checks++;
    if (word_o !== 32'h9ABC_DEF0 || word_valid_o !== 1'b1) begin
      errors++;
      $display("FAIL overrun_word: word %h valid %b expected 9abcdef0 1", word_o, word_valid_o);
    end
    word_ready_i = 1'b1;
    tick();
    word_ready_i = 1'b0;
    checks++;
    if (word_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL overrun_consume: valid %b expected 0", word_valid_o);
    end

    // Second pass: ready high exactly in the cycle word 2 completes.
    do_start(8'd2);
    strobe(1'b1, 1);
    strobe(1'b0, 1);
    send_word(32'h1234_5678, 1);
    for (int i = 31; i >= 1; i--) strobe(w2[i], 1);
    word_ready_i = 1'b1;
    strobe(w2[0], 0);
    word_ready_i = 1'b0;
    checks++;
    if (word_o !== 32'h9ABC_DEF0 || word_valid_o !== 1'b1 || overrun_o !== 1'b0) begin
      errors++;
      $display("FAIL sameslot_word: word %h valid %b overrun %b expected 9abcdef0 1 0",
               word_o, word_valid_o, overrun_o);
    end
    checks++;
    if (words_q.size() != 1 || words_q[0] !== 32'h1234_5678) begin
      errors++;
      $display("FAIL sameslot_accept: got %0d accepted words, expected one 12345678", words_q.size());
    end
    for (int i = 15; i >= 0; i--) strobe(calc_crc(wq) >> i, 1);
    strobe(1'b1, 1);
    wait_done();
    checks++;
    if (d_ovr !== 1'b0) begin
      errors++;
      $display("FAIL sameslot_overrun: overrun %b expected 0", d_ovr);
    end
    word_ready_i = 1'b1;
    tick();
  endtask

  task automatic test_end_err();
    word_ready_i = 1'b1;
    wq.delete();
    wq.push_back(32'h0000_0000);
    do_start(8'd1);
    send_block(wq, 16'h0000, 1'b0, 1);
    checks++;
    if (d_end !== 1'b1 || d_crc !== 1'b0) begin
      errors++;
      $display("FAIL end_err_flag: end_err %b crc_err %b expected 1 0", d_end, d_crc);
    end
    checks++;
    if (words_q.size() != 1 || words_q[0] !== 32'h0) begin
      errors++;
      $display("FAIL end_err_word: got %0d words expected one 00000000", words_q.size());
    end
  endtask

  task automatic test_abort();
    word_ready_i = 1'b0;
    do_start(8'd8);
    strobe(1'b1, 1);
    strobe(1'b0, 1);
    send_word(32'h1111_1111, 1);
    send_word(32'h2222_2222, 1);
    for (int i = 31; i >= 22; i--) strobe(1'b1, 1);
    checks++;
    if (word_valid_o !== 1'b1 || overrun_o !== 1'b1 || busy_o !== 1'b1) begin
      errors++;
      $display("FAIL abort_pre: valid %b overrun %b busy %b expected 1 1 1", word_valid_o, overrun_o, busy_o);
    end
    abort_i = 1'b1;
    start_i = 1'b1;
    tick();
    abort_i = 1'b0;
    start_i = 1'b0;
    checks++;
    if (busy_o !== 1'b0 || word_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL abort_idle: busy %b valid %b expected 0 0", busy_o, word_valid_o);
    end
    checks++;
    if (overrun_o !== 1'b1 || end_err_o !== 1'b0 || crc_err_o !== 1'b0) begin
      errors++;
      $display("FAIL abort_flags: overrun %b end_err %b crc_err %b expected 1 0 0",
               overrun_o, end_err_o, crc_err_o);
    end
    repeat (10) tick();
    checks++;
    if (done_cnt != 0 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL abort_no_done: done pulses %0d busy %b expected 0 0", done_cnt, busy_o);
    end
    word_ready_i = 1'b1;
    wq.delete();
    wq.push_back(32'hA5A5_0F0F);
    do_start(8'd1);
    send_block(wq, calc_crc(wq), 1'b1, 1);
    checks++;
    if (words_q.size() != 1 || words_q[0] !== 32'hA5A5_0F0F) begin
      errors++;
      $display("FAIL abort_restart_word: got %0d words expected one a5a50f0f", words_q.size());
    end
    checks++;
    if ({d_crc, d_end, d_ovr} !== 3'b000) begin
      errors++;
      $display("FAIL abort_restart_flags: crc/end/ovr=%b expected 000", {d_crc, d_end, d_ovr});
    end
  endtask

  task automatic test_reset_mid();
    word_ready_i = 1'b0;
    do_start(8'd8);
    strobe(1'b1, 1);
    strobe(1'b0, 1);
    send_word(32'hDEAD_BEEF, 1);
    strobe(1'b1, 1);
    checks++;
    if (word_valid_o !== 1'b1 || busy_o !== 1'b1 || word_o !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL rstmid_pre: valid %b busy %b word %h expected 1 1 deadbeef", word_valid_o, busy_o, word_o);
    end
    @(posedge clk_i);
    #4 rstn_i = 1'b0;
    #1;
    checks++;
    if ({word_o, word_valid_o, busy_o, done_o, crc_err_o, end_err_o, timeout_o, overrun_o} !== '0) begin
      errors++;
      $display("FAIL rstmid_async: outputs %h word %h expected all 0",
               {word_valid_o, busy_o, done_o, crc_err_o, end_err_o, timeout_o, overrun_o}, word_o);
    end
    tick();
    rstn_i = 1'b1;
    tick();
  endtask

  initial begin
    clkstrb_i    = 1'b0;
    start_i      = 1'b0;
    abort_i      = 1'b0;
    blklen_i     = '0;
    dat_i        = 1'b1;
    word_ready_i = 1'b1;
    done_cnt     = 0;
    test_reset();
    test_clean();
    test_crc_err();
    test_timeout();
    test_overrun();
    test_end_err();
    test_abort();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
